// File: rtl/agent_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : agent_pkg                                                        |
// | Purpose : Shared types and constants for the epsilon-greedy agent:        |
// |           decision FSM state encoding, LFSR tap mask and default seed,    |
// |           parameter defaults and the LFSR next-state helper.              |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package agent_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UPDATE = 3'd1,
    ST_SCAN   = 3'd2,
    ST_SELECT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] c_LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] c_DEFAULT_SEED = 16'hACE1;

  localparam int c_DEF_NUM_ACT  = 4;
  localparam int c_DEF_RW       = 16;
  localparam int c_DEF_VW       = 20;
  localparam int c_DEF_LR_SHIFT = 3;
  localparam int c_DEF_EPS_TH   = 26;
  localparam int c_DEF_EPS_MIN  = 4;

  // One shift of the register: feedback enters at bit 0, data moves up
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & c_LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lfsr16                                                           |
// | Purpose : 16-bit Fibonacci LFSR, advances one step when step is high.     |
// |           A zero seed is replaced by the default seed so the register     |
// |           can never lock up in the all-zero state.                        |
// | Ports   : clk  - clock, rising edge                                        |
// |           rst  - asynchronous active-high reset, loads seed               |
// |           seed - reset value                                               |
// |           step - advance enable                                            |
// |           q    - current register contents                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module lfsr16
  import agent_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= (seed == 16'h0000) ? c_DEFAULT_SEED : seed;
    end else if (step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/rl_agent_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rl_agent_param                                                   |
// | Purpose : Single-state epsilon-greedy bandit agent. Each accepted reward  |
// |           updates the value of the previous action, scans the value      |
// |           table for the argmax and selects the next action (greedy or    |
// |           random). Optional epsilon decay: define AGENT_EPS_DECAY_EN.     |
// | Ports   : clk     - clock, rising edge                                     |
// |           rst     - asynchronous active-high reset                         |
// |           v       - reward-valid strobe (accepted only when idle)          |
// |           r       - signed reward                                          |
// |           a       - chosen action                                          |
// |           d       - one-cycle decision-done pulse                          |
// |           explore - current action was a random choice                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rl_agent_param
  import agent_pkg::*;
#(
  parameter int          NUM_ACT  = c_DEF_NUM_ACT,
  parameter int          RW       = c_DEF_RW,
  parameter int          VW       = c_DEF_VW,
  parameter int          LR_SHIFT = c_DEF_LR_SHIFT,
  parameter int          EPS_TH   = c_DEF_EPS_TH,
  parameter logic [15:0] SEED     = c_DEFAULT_SEED
`ifdef AGENT_EPS_DECAY_EN
  ,
  parameter int          EPS_MIN  = c_DEF_EPS_MIN
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       v,
  input  logic signed [RW-1:0]       r,
  output logic [$clog2(NUM_ACT)-1:0] a,
  output logic                       d,
  output logic                       explore
);

  localparam int AW = $clog2(NUM_ACT);
  // Two guard bits: one for the difference, one for the sum
  localparam int SW = VW + 2;
  localparam logic signed [SW-1:0] c_QMAX = {{3{1'b0}}, {(VW-1){1'b1}}};
  localparam logic signed [SW-1:0] c_QMIN = {{3{1'b1}}, {(VW-1){1'b0}}};

  state_t                 state_q;
  logic [AW-1:0]          a_q;
  logic                   d_q;
  logic                   explore_q;
  logic                   has_prev_q;
  logic signed [RW-1:0]   r_q;
  logic [AW-1:0]          scan_idx_q;
  logic signed [VW-1:0]   best_val_q;
  logic [AW-1:0]          best_idx_q;
  logic signed [VW-1:0]   q_tbl_q [NUM_ACT];

  logic signed [VW-1:0]   w_q_cur;
  logic signed [VW-1:0]   w_q_scan;
  logic signed [SW-1:0]   w_r_ext;
  logic signed [SW-1:0]   w_q_ext;
  logic signed [SW-1:0]   w_diff;
  logic signed [SW-1:0]   w_step;
  logic signed [SW-1:0]   w_sum;
  logic signed [VW-1:0]   q_new_d;

  logic [15:0]            w_lfsr_q;
  logic [15:0]            w_lfsr_nxt;
  logic [7:0]             w_eps;
  logic                   w_unused_lfsr;

  assign w_q_cur  = q_tbl_q[a_q];
  assign w_q_scan = q_tbl_q[scan_idx_q];

  // Q[a] + ((r - Q[a]) >>> LR_SHIFT), saturated back to VW bits
  always_comb begin
    w_r_ext = {{(SW-RW){r_q[RW-1]}}, r_q};
    w_q_ext = {{2{w_q_cur[VW-1]}}, w_q_cur};
    w_diff  = w_r_ext - w_q_ext;
    w_step  = w_diff >>> LR_SHIFT;
    w_sum   = w_q_ext + w_step;
    q_new_d = w_sum[VW-1:0];
    if (w_sum > c_QMAX) begin
      q_new_d = c_QMAX[VW-1:0];
    end else if (w_sum < c_QMIN) begin
      q_new_d = c_QMIN[VW-1:0];
    end
  end

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .step (state_q == ST_SELECT),
    .q    (w_lfsr_q)
  );

  // The comparison uses the value the LFSR holds after this SELECT's step
  assign w_lfsr_nxt    = lfsr_next(w_lfsr_q);
  assign w_unused_lfsr = ^w_lfsr_nxt[15:8+AW];

`ifdef AGENT_EPS_DECAY_EN
  logic [7:0] eps_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eps_q <= 8'(EPS_TH);
    end else if ((state_q == ST_SELECT) && (eps_q > 8'(EPS_MIN))) begin
      eps_q <= eps_q - 8'd1;
    end
  end

  assign w_eps = eps_q;
`else
  assign w_eps = 8'(EPS_TH);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      d_q        <= 1'b0;
      explore_q  <= 1'b0;
      has_prev_q <= 1'b0;
      r_q        <= '0;
      scan_idx_q <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      for (int i = 0; i < NUM_ACT; i++) begin
        q_tbl_q[i] <= '0;
      end
    end else begin
      // d is registered off the DONE state, so it rises as DONE is left
      d_q <= (state_q == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (v) begin
            r_q     <= r;
            state_q <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (has_prev_q) begin
            q_tbl_q[a_q] <= q_new_d;
          end
          has_prev_q <= 1'b1;
          scan_idx_q <= '0;
          state_q    <= ST_SCAN;
        end
        ST_SCAN: begin
          // Strict greater-than keeps the lowest index on ties
          if ((scan_idx_q == '0) || (w_q_scan > best_val_q)) begin
            best_val_q <= w_q_scan;
            best_idx_q <= scan_idx_q;
          end
          if (scan_idx_q == AW'(NUM_ACT - 1)) begin
            state_q <= ST_SELECT;
          end else begin
            scan_idx_q <= scan_idx_q + 1'b1;
          end
        end
        ST_SELECT: begin
          if (w_lfsr_nxt[7:0] < w_eps) begin
            a_q       <= w_lfsr_nxt[8+AW-1:8];
            explore_q <= 1'b1;
          end else begin
            a_q       <= best_idx_q;
            explore_q <= 1'b0;
          end
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a       = a_q;
  assign d       = d_q;
  assign explore = explore_q;

endmodule
`default_nettype wire

// File: tb/tb_rl_agent_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_rl_agent_param                                                |
// | Purpose : Directed self-checking bench for rl_agent_param. Three          |
// |           instances: dut0 greedy (EPS_TH=0), dut1 always-explore         |
// |           (EPS_TH=255), dut2 narrow value table (VW=17).                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_rl_agent_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               v_s  [3];
  logic signed [15:0] r_s  [3];
  logic [1:0]         a_s  [3];
  logic               d_s  [3];
  logic               ex_s [3];

  int npass = 0;
  int ntot  = 0;

  rl_agent_param #(.EPS_TH(0)) dut0 (
    .clk(clk), .rst(rst), .v(v_s[0]), .r(r_s[0]),
    .a(a_s[0]), .d(d_s[0]), .explore(ex_s[0])
  );

  rl_agent_param #(.EPS_TH(255)) dut1 (
    .clk(clk), .rst(rst), .v(v_s[1]), .r(r_s[1]),
    .a(a_s[1]), .d(d_s[1]), .explore(ex_s[1])
  );

  rl_agent_param #(.VW(17), .EPS_TH(0)) dut2 (
    .clk(clk), .rst(rst), .v(v_s[2]), .r(r_s[2]),
    .a(a_s[2]), .d(d_s[2]), .explore(ex_s[2])
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Pulse v for one cycle, wait (bounded) for d, check latency and pulse width
  task automatic decide(input int sel, input int rv, input string tag);
    int lat;
    @(negedge clk);
    v_s[sel] = 1'b1;
    r_s[sel] = 16'(rv);
    @(posedge clk);
    #1 v_s[sel] = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (d_s[sel]) break;
    end
    check({tag, "_latency"}, lat, 7);
    @(posedge clk);
    #1 check({tag, "_d_width"}, d_s[sel], 0);
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stim
    int          nd;
    logic [15:0] lf;
    logic        exp_ex;
    logic [1:0]  exp_a;
    int          mq [4];
    int          ma;
    int          hp;
    int          rv;
    int          qo;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v_s[i] = 1'b0;
      r_s[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_a",       a_s[0], 0);
    check("reset_d",       d_s[0], 0);
    check("reset_explore", ex_s[0], 0);
    check("reset_q0",      dut0.q_tbl_q[0], 0);
    @(negedge clk);
    rst = 1'b0;

    // First decision: no update, greedy pick of an all-zero table
    decide(0, 1000, "first");
    check("first_a",       a_s[0], 0);
    check("first_explore", ex_s[0], 0);
    check("first_q0",      dut0.q_tbl_q[0], 0);

    decide(0, 800, "r800");
    check("r800_q0", dut0.q_tbl_q[0], 100);
    check("r800_a",  a_s[0], 0);

    // -1700 >>> 3 floors to -213
    decide(0, -1600, "rneg");
    check("rneg_q0", dut0.q_tbl_q[0], -113);
    check("rneg_a",  a_s[0], 1);

    // Accepted v then extra v pulses sampled 2 and 4 edges later
    @(negedge clk);
    v_s[0] = 1'b1;
    r_s[0] = 16'sd80;
    @(posedge clk);
    #1 v_s[0] = 1'b0;
    nd = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (d_s[0]) nd++;
      v_s[0] = (c == 1) || (c == 3);
      r_s[0] = 16'sd8000;
    end
    check("extra_v_d_count", nd, 1);
    check("extra_v_q1",      dut0.q_tbl_q[1], 10);
    check("extra_v_q0",      dut0.q_tbl_q[0], -113);
    check("extra_v_a",       a_s[0], 1);

    // Reset during SCAN aborts the decision
    @(negedge clk);
    v_s[0] = 1'b1;
    r_s[0] = 16'sd300;
    @(posedge clk);
    #1 v_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_a", a_s[0], 0);
    check("midrst_d", d_s[0], 0);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("midrst_q%0d", j), dut0.q_tbl_q[j], 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (d_s[0]) nd++;
    end
    check("midrst_no_d", nd, 0);

    decide(0, 500, "after_rst");
    check("after_rst_a",  a_s[0], 0);
    check("after_rst_q0", dut0.q_tbl_q[0], 0);
    check("after_rst_q1", dut0.q_tbl_q[1], 0);

    // dut1: exploration threshold 255 against a reference LFSR
    lf = 16'hACE1;
    for (int k = 0; k < 20; k++) begin
      decide(1, 0, $sformatf("expl%0d", k));
      lf     = ref_lfsr(lf);
      exp_ex = (lf[7:0] < 8'd255);
      exp_a  = exp_ex ? lf[9:8] : 2'd0;
      check($sformatf("expl%0d_explore", k), ex_s[1], exp_ex);
      check($sformatf("expl%0d_a", k),       a_s[1],  exp_a);
    end

    // dut2: 17-bit value table with extreme rewards
    mq = '{0, 0, 0, 0};
    ma = 0;
    hp = 0;
    for (int k = 0; k < 14; k++) begin
      rv = (k < 7) ? 32767 : -32768;
      decide(2, rv, $sformatf("vw17_%0d", k));
      if (hp != 0) begin
        mq[ma] = mq[ma] + ((rv - mq[ma]) >>> 3);
        if (mq[ma] > 65535)  mq[ma] = 65535;
        if (mq[ma] < -65536) mq[ma] = -65536;
      end
      hp = 1;
      ma = 0;
      for (int j = 1; j < 4; j++) begin
        if (mq[j] > mq[ma]) ma = j;
      end
      for (int j = 0; j < 4; j++) begin
        qo = int'(dut2.q_tbl_q[j]);
        check($sformatf("vw17_%0d_q%0d", k, j), qo, mq[j]);
        check($sformatf("vw17_%0d_range%0d", k, j),
              ((qo >= -65536) && (qo <= 65535)) ? 1 : 0, 1);
      end
      check($sformatf("vw17_%0d_a", k), a_s[2], ma);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rl_agent_param.md
RL_AGENT_PARAM -- requirements
Module: rl_agent_param

Interface
REQ-001 SHALL have parameter NUM_ACT, default 4, number of actions; power of two, 2..16.
REQ-002 SHALL have parameter RW, default 16, reward width, signed two's complement.
REQ-003 SHALL have parameter VW, default 20, value-table entry width, signed, VW >= RW+1.
REQ-004 SHALL have parameter LR_SHIFT, default 3, learning rate 2^-LR_SHIFT.
REQ-005 SHALL have parameter EPS_TH, default 26, 8-bit exploration threshold (26/256 ≈ 10%).
REQ-006 SHALL have parameter SEED, default 16'hACE1, LFSR seed; 0 is replaced by 16'hACE1.
REQ-007 SHALL have port clk  in  1  sole clock, rising edge.
REQ-008 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have port v  in  1  reward-valid strobe.
REQ-010 SHALL have port r  in  RW  reward, sampled when v accepted.
REQ-011 SHALL have port a  out  AW=$clog2(NUM_ACT)  chosen action, stable from d until next d.
REQ-012 SHALL have port d  out  1  decision-done pulse.
REQ-013 SHALL have port explore  out  1  high when current a is an exploratory (random) choice.

Function
REQ-014 SHALL implement FSM IDLE -> UPDATE -> SCAN -> SELECT -> DONE -> IDLE.
REQ-015 In IDLE only, v=1 SHALL be accepted: r captured, next state UPDATE; v in any other state is ignored.
REQ-016 UPDATE SHALL, if has_prev=1, write Q[a] <= sat_VW(Q[a] + ((sext(r) - Q[a]) >>> LR_SHIFT)) using arithmetic shift (floor); if has_prev=0, no write; has_prev set to 1 on exit.
REQ-017 sat_VW SHALL clamp to [-2^(VW-1), 2^(VW-1)-1].
REQ-018 SCAN SHALL take exactly NUM_ACT cycles, one entry per cycle, index 0 first, producing argmax; ties resolve to lowest index.
REQ-019 SELECT SHALL advance the 16-bit LFSR once; if lfsr[7:0] < eps then a <= lfsr[8+AW-1:8], explore <= 1, else a <= argmax, explore <= 0.
REQ-020 DONE SHALL drive d=1 for exactly one cycle, then return to IDLE.
REQ-021 Latency SHALL be NUM_ACT+3 rising edges from the edge sampling v to the edge at which d rises.
REQ-022 LFSR SHALL be Fibonacci, taps 16,14,13,11, never entering all-zero state.
REQ-023 eps SHALL equal EPS_TH except as modified by REQ-028.

Reset
REQ-024 rst=1 SHALL asynchronously force: state IDLE, a=0, d=0, explore=0, all Q entries 0, has_prev=0, lfsr=SEED (or 16'hACE1), eps=EPS_TH.
REQ-025 Reset mid-operation SHALL abort the decision with no d pulse; the next accepted v behaves as the first after reset.

Configuration
REQ-026 Macro AGENT_EPS_DECAY_EN SHALL select epsilon decay.
REQ-027 Without AGENT_EPS_DECAY_EN, eps SHALL be constant EPS_TH.
REQ-028 With AGENT_EPS_DECAY_EN, eps SHALL decrement by 1 in each SELECT after the comparison, floored at parameter EPS_MIN (default 4; present only when defined).

Structure
REQ-029 Package agent_pkg SHALL hold the FSM state enum typedef, LFSR tap constant, default seed and parameter defaults.
REQ-030 Sub-module lfsr16 (clk, rst, seed, step, q) SHALL implement the LFSR; the rest stays in rl_agent_param.

Verification (NUM_ACT=4, EPS_TH=0 unless stated)
REQ-031 After reset, v with r=1000 -> no Q update, a=0, explore=0, d high exactly one cycle, 7 edges after v sample.
REQ-032 Then v with r=800 -> Q[0]=100, a=0; then r=-1600 -> Q[0]=100+(-1700>>>3)=-113, a=1.
REQ-033 Extra v pulses 2 and 4 cycles after an accepted v -> exactly one d; Q unchanged by ignored pulses.
REQ-034 rst asserted during SCAN -> d never pulses, a=0, Q all 0; next v with r=500 -> no update, a=0.
REQ-035 EPS_TH=255 (no decay), 20 decisions -> every explore=1, a equal to lfsr[9:8] from a reference LFSR model seeded 16'hACE1.
REQ-036 VW=17, repeated r=32767 and r=-32768 -> Q stays within [-65536, 65535], no wrap.
